crack_ctrl: RTL and testbench
=============================

Name: crack_ctrl

Overview:
- Top-level scheduler for NUM_CORES parallel brute-force crack cores.
- Core i searches keys i, i+NUM_CORES, i+2·NUM_CORES, ….
- Releases and launches all cores together, then watches them finish.
- Picks the first core reporting a valid key, latches that key, and halts the losing cores.
- Copies the winner's local plaintext memory into the shared plaintext memory as a length-prefixed string.

Parameters:
NUM_CORES, 4, number of crack cores (1..16)
KEY_W, 24, key width in bits
ADDR_W, 8, plaintext address/data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a crack run; sampled only in S_IDLE
rdy  out  1  high in S_IDLE, S_DONE_GOOD, S_DONE_BAD
key  out  KEY_W  winning key; valid when key_valid=1
key_valid  out  1  high only in S_DONE_GOOD
num_cores  out  8  constant NUM_CORES, fanned out to every core
core_rst_n  out  NUM_CORES  per-core active-low synchronous reset
core_en  out  NUM_CORES  per-core one-cycle start pulse
core_rdy  in  NUM_CORES  per-core ready
core_key_valid  in  NUM_CORES  per-core key found
core_key  in  NUM_CORES*KEY_W  per-core key, core i at bits [i*KEY_W +: KEY_W]
pt_rd_addr  out  ADDR_W  read address, broadcast to all cores' local plaintext memories
core_pt_rddata  in  NUM_CORES*ADDR_W  per-core local plaintext read data; 1-cycle latency
pt_wren  out  1  shared plaintext write enable
pt_addr  out  ADDR_W  shared plaintext write address
pt_wrdata  out  ADDR_W  shared plaintext write data
winner  out  4  index of the winning core

Behaviour:
- Clock is clk. rst is synchronous and active-high; it wins over every other input.
- Reset values:
  - state = S_IDLE, rdy = 1
  - key = 0, key_valid = 0, winner = 0
  - core_en = 0, core_rst_n = all 0
  - pt_wren = 0, pt_addr = 0, pt_wrdata = 0, pt_rd_addr = 0
- States:
  - S_IDLE: core_rst_n all 0. On start, go to S_CLR. start outside S_IDLE is ignored; a new run requires rst.
  - S_CLR: core_rst_n stays 0 for exactly 1 cycle. Clear per-core busy_seen bits. Go to S_WAITRDY.
  - S_WAITRDY: core_rst_n all 1. Wait until core_rdy is all ones, then go to S_LAUNCH.
  - S_LAUNCH: core_en all ones for exactly one cycle. Go to S_RUN.
  - S_RUN:
    - busy_seen[i] sets when core_rdy[i] = 0.
    - Core i has finished when busy_seen[i] & core_rdy[i].
    - If any finished core has core_key_valid = 1: winner = lowest such index; latch key from that core's core_key; drive core_rst_n[j] = 0 for every j ≠ winner; go to S_CPLEN.
    - Else if all cores have finished: go to S_DONE_BAD.
    - Same-cycle valid and failed finishes: the valid one wins.
  - S_CPLEN: pt_rd_addr = 0.
  - S_CPY, per cycle, with i starting at 0:
    - Capture d = winner's core_pt_rddata.
    - If i = 0, latch L = d.
    - Write pt_addr = i, pt_wrdata = d, pt_wren = 1.
    - If i = L, go to S_DONE_GOOD. Otherwise set pt_rd_addr = i+1 and i = i+1.
    - Net effect: L+1 writes at addresses 0..L, back-to-back, one per cycle.
    - L = 0: exactly one write.
    - L = 255: last write at address 255; no wrap. i is held in ADDR_W+1 bits for the compare.
  - S_DONE_GOOD: rdy = 1, key_valid = 1. Losing cores stay in reset; the winner is untouched. Held until rst.
  - S_DONE_BAD: rdy = 1, key_valid = 0, key = 0. All cores stay out of reset. Held until rst.
- pt_wren is 0 in every state except S_CPY.
- Latency:
  - start to first core_en: 3 cycles minimum (S_CLR, S_WAITRDY, S_LAUNCH).
  - Winner detection to first pt_wren: 2 cycles.
- rst mid-run or mid-copy: next cycle is S_IDLE with all cores in reset. A partially written shared plaintext is not cleaned up.

Decomposition:
- Package crack_pkg holds:
  - ctrl_state_t enum: S_IDLE, S_CLR, S_WAITRDY, S_LAUNCH, S_RUN, S_CPLEN, S_CPY, S_DONE_GOOD, S_DONE_BAD
  - KEY_W_DEF = 24, PT_AW = 8, MAX_CORES = 16
- Sub-module crack_winner_sel: combinational lowest-index priority encoder over finished & key_valid. Outputs found and idx.

Test Plan:
1. NUM_CORES=4; core 2 finishes valid with key 0x00000A and local pt = {3,'a','b','c'} -> winner=2, key=0x00000A, key_valid=1; writes (0,3),(1,'a'),(2,'b'),(3,'c') on consecutive cycles; core_rst_n=4'b0100.
2. Cores 1 and 3 report valid in the same cycle -> winner=1 and core 1's key is latched.
3. All four cores finish with key_valid=0 -> S_DONE_BAD, rdy=1, key_valid=0, no pt_wren ever asserted.
4. Winner's pt[0]=0 -> exactly one write (0,0); pt[0]=255 -> 256 writes, last at address 255, no wrap.
5. rst asserted during S_CPY after 5 writes -> next cycle rdy=1, pt_wren=0, core_rst_n=0; start pulses outside S_IDLE are ignored.
6. start asserted while core_rdy=4'b1011 -> core_en stays 0 until core_rdy=4'b1111, then exactly one 4'b1111 pulse.

Source files
------------

// File: rtl/crack_pkg.sv
// ============================================================================
// Module      : crack_pkg
// Description : Shared types and constants for the crack core scheduler.
//               Holds the controller state encoding and the default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crack_pkg;

   // Controller states, explicitly 4 bits wide
   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CLR       = 4'd1,
      S_WAITRDY   = 4'd2,
      S_LAUNCH    = 4'd3,
      S_RUN       = 4'd4,
      S_CPLEN     = 4'd5,
      S_CPY       = 4'd6,
      S_DONE_GOOD = 4'd7,
      S_DONE_BAD  = 4'd8
   } ctrl_state_t;

   localparam int KEY_W_DEF = 24;
   localparam int PT_AW     = 8;
   localparam int MAX_CORES = 16;
   // Width of a core index; covers every legal core count
   localparam int IDX_W     = $clog2(MAX_CORES);

endpackage

`default_nettype wire

// File: rtl/crack_winner_sel.sv
// ============================================================================
// Module      : crack_winner_sel
// Description : Lowest-index priority encoder over cores that have finished
//               and hold a valid key.
// Ports       : finished  - per-core finished flags
//               key_valid - per-core key-found flags
//               found     - at least one finished core has a valid key
//               idx       - lowest index of such a core (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crack_winner_sel
   import crack_pkg::*;
#(
   parameter int NUM_CORES = 4
) (
   input  logic [NUM_CORES-1:0] finished,
   input  logic [NUM_CORES-1:0] key_valid,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   logic [NUM_CORES-1:0] hit;

   assign hit = finished & key_valid;

   // Walk from the top down so the lowest set index is the last one written
   always_comb begin
      found = |hit;
      idx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/crack_ctrl.sv
// ============================================================================
// Module      : crack_ctrl
// Description : Scheduler for NUM_CORES parallel brute-force crack cores.
//               Resets and launches all cores together, picks the first core
//               reporting a valid key, halts the losers and copies the
//               winner's length-prefixed plaintext into shared memory.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, rdy          - run request / controller idle or done
//               key, key_valid      - winning key and its qualifier
//               winner              - index of the winning core
//               num_cores           - core count broadcast to every core
//               core_rst_n, core_en - per-core reset and launch pulse
//               core_rdy, core_key_valid, core_key - per-core status
//               pt_rd_addr, core_pt_rddata - local plaintext read port
//               pt_wren, pt_addr, pt_wrdata - shared plaintext write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crack_ctrl
   import crack_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int KEY_W     = KEY_W_DEF,
   parameter int ADDR_W    = PT_AW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        rdy,
   output logic [KEY_W-1:0]            key,
   output logic                        key_valid,
   output logic [7:0]                  num_cores,
   output logic [NUM_CORES-1:0]        core_rst_n,
   output logic [NUM_CORES-1:0]        core_en,
   input  logic [NUM_CORES-1:0]        core_rdy,
   input  logic [NUM_CORES-1:0]        core_key_valid,
   input  logic [NUM_CORES*KEY_W-1:0]  core_key,
   output logic [ADDR_W-1:0]           pt_rd_addr,
   input  logic [NUM_CORES*ADDR_W-1:0] core_pt_rddata,
   output logic                        pt_wren,
   output logic [ADDR_W-1:0]           pt_addr,
   output logic [ADDR_W-1:0]           pt_wrdata,
   output logic [3:0]                  winner
);

   localparam logic [ADDR_W:0]   IDX_ONE = 1;
   localparam logic [ADDR_W-1:0] RD_ONE  = 1;

   ctrl_state_t          state_q, state_d;
   logic [NUM_CORES-1:0] busy_seen_q, busy_seen_d;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [IDX_W-1:0]     winner_q, winner_d;
   logic [ADDR_W:0]      idx_q, idx_d;      // one extra bit so L=255 ends without wrap
   logic [ADDR_W-1:0]    len_q, len_d;

   logic [NUM_CORES-1:0] finished;
   logic                 found;
   logic [IDX_W-1:0]     found_idx;
   logic [KEY_W-1:0]     found_key;
   logic [ADDR_W-1:0]    cpy_data;
   logic [ADDR_W-1:0]    cpy_len;
   logic                 cpy_last;
   logic [NUM_CORES-1:0] winner_oh;

   // A core counts as finished only once it has been seen busy this run,
   // so the ready level left over from launch is not mistaken for a finish.
   assign finished = busy_seen_q & core_rdy;

   crack_winner_sel #(
      .NUM_CORES (NUM_CORES)
   ) u_winner_sel (
      .finished  (finished),
      .key_valid (core_key_valid),
      .found     (found),
      .idx       (found_idx)
   );

   // Per-core muxes written as loops so no select can index past NUM_CORES
   always_comb begin
      found_key = '0;
      cpy_data  = '0;
      winner_oh = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         if (found_idx == IDX_W'(j)) begin
            found_key = core_key[j*KEY_W +: KEY_W];
         end
         if (winner_q == IDX_W'(j)) begin
            cpy_data     = core_pt_rddata[j*ADDR_W +: ADDR_W];
            winner_oh[j] = 1'b1;
         end
      end
   end

   // The length byte arrives on the first copy cycle, before it can be latched
   assign cpy_len  = (idx_q == '0) ? cpy_data : len_q;
   assign cpy_last = (idx_q == {1'b0, cpy_len});

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      busy_seen_d = busy_seen_q;
      key_d       = key_q;
      winner_d    = winner_q;
      idx_d       = idx_q;
      len_d       = len_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLR;
         end
         S_CLR: begin
            busy_seen_d = '0;
            state_d     = S_WAITRDY;
         end
         S_WAITRDY: begin
            if (&core_rdy) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            busy_seen_d = busy_seen_q | ~core_rdy;
            // A valid finish takes precedence over all cores having finished
            if (found) begin
               winner_d = found_idx;
               key_d    = found_key;
               state_d  = S_CPLEN;
            end else if (&finished) begin
               state_d = S_DONE_BAD;
            end
         end
         S_CPLEN: begin
            idx_d   = '0;
            state_d = S_CPY;
         end
         S_CPY: begin
            if (idx_q == '0) len_d = cpy_data;
            if (cpy_last) begin
               state_d = S_DONE_GOOD;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         S_DONE_GOOD: state_d = S_DONE_GOOD;
         S_DONE_BAD:  state_d = S_DONE_BAD;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      rdy        = 1'b0;
      key_valid  = 1'b0;
      core_en    = '0;
      core_rst_n = '0;
      pt_wren    = 1'b0;
      pt_addr    = '0;
      pt_wrdata  = '0;
      pt_rd_addr = '0;
      case (state_q)
         S_IDLE: begin
            rdy = 1'b1;
         end
         S_WAITRDY, S_RUN: begin
            core_rst_n = '1;
         end
         S_LAUNCH: begin
            core_rst_n = '1;
            core_en    = '1;
         end
         S_CPLEN: begin
            core_rst_n = winner_oh;
         end
         S_CPY: begin
            core_rst_n = winner_oh;
            pt_wren    = 1'b1;
            pt_addr    = idx_q[ADDR_W-1:0];
            pt_wrdata  = cpy_data;
            // Read address runs one ahead of the write so the copy is gapless
            pt_rd_addr = cpy_last ? idx_q[ADDR_W-1:0] : (idx_q[ADDR_W-1:0] + RD_ONE);
         end
         S_DONE_GOOD: begin
            rdy        = 1'b1;
            key_valid  = 1'b1;
            core_rst_n = winner_oh;
         end
         S_DONE_BAD: begin
            rdy        = 1'b1;
            core_rst_n = '1;
         end
         default: begin
            rdy = 1'b0;
         end
      endcase
   end

   assign key       = key_q;
   assign winner    = winner_q;
   assign num_cores = 8'(NUM_CORES);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_seen_q <= '0;
         key_q       <= '0;
         winner_q    <= '0;
         idx_q       <= '0;
         len_q       <= '0;
      end else begin
         state_q     <= state_d;
         busy_seen_q <= busy_seen_d;
         key_q       <= key_d;
         winner_q    <= winner_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_crack_ctrl.sv
// ============================================================================
// Module      : tb_crack_ctrl
// Description : Self-checking bench for crack_ctrl with behavioural crack
//               cores, local plaintext RAMs and a transaction-level model of
//               the expected winner, key and shared-memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crack_ctrl;

   localparam int NC = 4;
   localparam int KW = 24;
   localparam int AW = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             rdy;
   logic [KW-1:0]    key;
   logic             key_valid;
   logic [7:0]       num_cores;
   logic [NC-1:0]    core_rst_n;
   logic [NC-1:0]    core_en;
   logic [NC-1:0]    core_rdy;
   logic [NC-1:0]    core_key_valid;
   logic [NC*KW-1:0] core_key;
   logic [AW-1:0]    pt_rd_addr;
   logic [NC*AW-1:0] core_pt_rddata;
   logic             pt_wren;
   logic [AW-1:0]    pt_addr;
   logic [AW-1:0]    pt_wrdata;
   logic [3:0]       winner;

   crack_ctrl #(
      .NUM_CORES (NC),
      .KEY_W     (KW),
      .ADDR_W    (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .rdy            (rdy),
      .key            (key),
      .key_valid      (key_valid),
      .num_cores      (num_cores),
      .core_rst_n     (core_rst_n),
      .core_en        (core_en),
      .core_rdy       (core_rdy),
      .core_key_valid (core_key_valid),
      .core_key       (core_key),
      .pt_rd_addr     (pt_rd_addr),
      .core_pt_rddata (core_pt_rddata),
      .pt_wren        (pt_wren),
      .pt_addr        (pt_addr),
      .pt_wrdata      (pt_wrdata),
      .winner         (winner)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- per-test core configuration ----------------
   int          cfg_run   [NC];
   bit          cfg_valid [NC];
   logic [KW-1:0] cfg_key [NC];
   bit          hold_rdy  [NC];
   logic [7:0]  mem [NC][256];

   // ---------------- core behaviour state ----------------
   int          c_cnt  [NC];
   bit          c_busy [NC];

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   logic [7:0]  log_addr [512];
   logic [7:0]  log_data [512];
   int          wr_count;
   int          en_pulses;
   int          cyc = 0;
   int          first_valid_cyc;
   int          start_cyc;
   bit          arm_lat;
   bit          lat_check;

   // Local plaintext RAMs: registered read, one cycle of latency
   always @(posedge clk) begin
      for (int i = 0; i < NC; i++) begin
         core_pt_rddata[i*AW +: AW] <= mem[i][pt_rd_addr];
      end
   end

   // Compare process followed by the crack-core behaviour, once per cycle
   always @(negedge clk) begin
      logic [15:0] e;
      bit          hold_any;
      cyc++;
      hold_any = 1'b0;
      for (int i = 0; i < NC; i++) hold_any |= hold_rdy[i];

      if (arm_lat && start) begin
         start_cyc = cyc;
         arm_lat   = 1'b0;
      end
      if (core_en != '0) begin
         chk("core_en_all_cores", 32'(core_en), 32'hF);
         chk("core_en_after_all_ready", 32'(hold_any), 32'h0);
         en_pulses++;
         if (lat_check) begin
            chk("start_to_core_en", 32'(cyc - start_cyc), 32'd3);
            lat_check = 1'b0;
         end
      end
      if (pt_wren) begin
         chk("wren_only_when_busy", 32'(rdy), 32'h0);
         if (wr_count == 0 && first_valid_cyc >= 0) begin
            chk("detect_to_first_write", 32'(cyc - first_valid_cyc), 32'd2);
         end
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(pt_wren), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("pt_addr", 32'(pt_addr), 32'(e[15:8]));
            chk("pt_wrdata", 32'(pt_wrdata), 32'(e[7:0]));
         end
         if (wr_count < 512) begin
            log_addr[wr_count] = pt_addr;
            log_data[wr_count] = pt_wrdata;
         end
         wr_count++;
      end else if (wr_count > 0 && exp_q.size() > 0) begin
         chk("writes_back_to_back", 32'(pt_wren), 32'h1);
      end
      if (key_valid) chk("key_valid_implies_rdy", 32'(rdy), 32'h1);

      for (int i = 0; i < NC; i++) begin
         if (!core_rst_n[i]) begin
            core_rdy[i]          = 1'b0;
            core_key_valid[i]    = 1'b0;
            core_key[i*KW +: KW] = '0;
            c_busy[i]            = 1'b0;
         end else if (core_en[i]) begin
            core_rdy[i]       = 1'b0;
            core_key_valid[i] = 1'b0;
            c_cnt[i]          = cfg_run[i];
            c_busy[i]         = 1'b1;
         end else if (c_busy[i]) begin
            c_cnt[i]--;
            if (c_cnt[i] == 0) begin
               c_busy[i]            = 1'b0;
               core_rdy[i]          = 1'b1;
               core_key_valid[i]    = cfg_valid[i];
               core_key[i*KW +: KW] = cfg_key[i];
               if (cfg_valid[i] && first_valid_cyc < 0) first_valid_cyc = cyc;
            end
         end else if (!core_rdy[i] && !hold_rdy[i]) begin
            core_rdy[i] = 1'b1;
         end
      end
   end

   // ---------------- model ----------------
   // All cores start together, so the earliest valid finisher wins; ties go
   // to the lowest index (strict < while scanning upward).
   function automatic int model_winner();
      int best = -1;
      for (int i = 0; i < NC; i++) begin
         if (cfg_valid[i] && (best < 0 || cfg_run[i] < cfg_run[best])) best = i;
      end
      return best;
   endfunction

   task automatic load_expected();
      int w;
      exp_q.delete();
      w = model_winner();
      if (w >= 0) begin
         for (int a = 0; a <= int'(mem[w][0]); a++) begin
            exp_q.push_back({8'(a), mem[w][a]});
         end
      end
   endtask

   task automatic cfg_core(input int i, input int run, input bit v, input logic [KW-1:0] k);
      cfg_run[i]   = run;
      cfg_valid[i] = v;
      cfg_key[i]   = k;
      hold_rdy[i]  = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < NC; i++)
         for (int a = 0; a < 256; a++) mem[i][a] = 8'(a + 16 * i);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      wr_count        = 0;
      en_pulses       = 0;
      first_valid_cyc = -1;
      arm_lat         = 1'b0;
      lat_check       = 1'b0;
      chk("rst_rdy", 32'(rdy), 32'h1);
      chk("rst_key", 32'(key), 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_winner", 32'(winner), 32'h0);
      chk("rst_core_en", 32'(core_en), 32'h0);
      chk("rst_core_rst_n", 32'(core_rst_n), 32'h0);
      chk("rst_pt_wren", 32'(pt_wren), 32'h0);
      chk("rst_pt_addr", 32'(pt_addr), 32'h0);
      chk("rst_pt_wrdata", 32'(pt_wrdata), 32'h0);
      chk("rst_pt_rd_addr", 32'(pt_rd_addr), 32'h0);
      chk("num_cores", 32'(num_cores), 32'd4);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input bit check_lat);
      load_expected();
      arm_lat   = 1'b1;
      lat_check = check_lat;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (rdy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      n = 0;
      while (!rdy && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("run_completes", 32'(rdy), 32'h1);
   endtask

   task automatic final_checks();
      int w;
      w = model_winner();
      chk("one_launch_pulse", 32'(en_pulses), 32'd1);
      chk("all_writes_done", 32'(exp_q.size()), 32'd0);
      if (w >= 0) begin
         chk("winner", 32'(winner), 32'(w));
         chk("key", 32'(key), 32'(cfg_key[w]));
         chk("key_valid_good", 32'(key_valid), 32'h1);
         chk("core_rst_n_good", 32'(core_rst_n), 32'(1 << w));
         chk("write_count", 32'(wr_count), 32'(int'(mem[w][0]) + 1));
      end else begin
         chk("key_valid_bad", 32'(key_valid), 32'h0);
         chk("key_bad", 32'(key), 32'h0);
         chk("core_rst_n_bad", 32'(core_rst_n), 32'hF);
         chk("write_count_bad", 32'(wr_count), 32'd0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      core_rdy       = '0;
      core_key_valid = '0;
      core_key       = '0;
      for (int i = 0; i < NC; i++) begin
         c_busy[i] = 1'b0;
         c_cnt[i]  = 0;
         cfg_core(i, 10, 1'b0, '0);
      end
      clear_mem();

      // 1: core 2 alone finds key 0x00000A, plaintext "abc"
      clear_mem();
      cfg_core(0, 12, 1'b0, 24'h111111);
      cfg_core(1, 12, 1'b0, 24'h222222);
      cfg_core(2,  4, 1'b1, 24'h00000A);
      cfg_core(3, 12, 1'b0, 24'h444444);
      mem[2][0] = 8'd3; mem[2][1] = 8'h61; mem[2][2] = 8'h62; mem[2][3] = 8'h63;
      do_reset();
      do_start(1'b1);
      wait_done();
      final_checks();
      chk("t1_winner", 32'(winner), 32'd2);
      chk("t1_key", 32'(key), 32'h00000A);
      chk("t1_core_rst_n", 32'(core_rst_n), 32'b0100);
      chk("t1_wr0", {16'h0, log_addr[0], log_data[0]}, 32'h0003);
      chk("t1_wr1", {16'h0, log_addr[1], log_data[1]}, 32'h0161);
      chk("t1_wr2", {16'h0, log_addr[2], log_data[2]}, 32'h0262);
      chk("t1_wr3", {16'h0, log_addr[3], log_data[3]}, 32'h0363);
      // start in a done state must not relaunch anything
      pulse_start();
      repeat (5) @(posedge clk);
      #1;
      chk("t1_done_held", 32'(key_valid), 32'h1);
      chk("t1_no_relaunch", 32'(en_pulses), 32'd1);
      chk("t1_core_rst_n_held", 32'(core_rst_n), 32'b0100);

      // 2: cores 1 and 3 valid in the same cycle, core 0 valid later
      clear_mem();
      cfg_core(0, 9, 1'b1, 24'hABC000);
      cfg_core(1, 5, 1'b1, 24'hABC001);
      cfg_core(2, 9, 1'b0, 24'hABC002);
      cfg_core(3, 5, 1'b1, 24'hABC003);
      mem[1][0] = 8'd2; mem[1][1] = 8'h11; mem[1][2] = 8'h22;
      do_reset();
      do_start(1'b1);
      repeat (3) @(posedge clk);
      #1;
      pulse_start();
      wait_done();
      final_checks();
      chk("t2_winner", 32'(winner), 32'd1);
      chk("t2_key", 32'(key), 32'hABC001);

      // 3: every core fails
      clear_mem();
      cfg_core(0, 3, 1'b0, 24'h000101);
      cfg_core(1, 4, 1'b0, 24'h000102);
      cfg_core(2, 5, 1'b0, 24'h000103);
      cfg_core(3, 6, 1'b0, 24'h000104);
      do_reset();
      do_start(1'b1);
      wait_done();
      final_checks();
      chk("t3_no_writes", 32'(wr_count), 32'd0);
      chk("t3_key_valid", 32'(key_valid), 32'h0);

      // 4a: zero-length plaintext, single write
      clear_mem();
      cfg_core(0, 3, 1'b1, 24'h0C0FFE);
      cfg_core(1, 8, 1'b0, 24'h0);
      cfg_core(2, 8, 1'b0, 24'h0);
      cfg_core(3, 8, 1'b0, 24'h0);
      mem[0][0] = 8'd0;
      do_reset();
      do_start(1'b0);
      wait_done();
      final_checks();
      chk("t4a_one_write", 32'(wr_count), 32'd1);
      chk("t4a_wr0", {16'h0, log_addr[0], log_data[0]}, 32'h0000);

      // 4b: maximum length, 256 writes ending at address 255
      clear_mem();
      cfg_core(0, 8, 1'b0, 24'h0);
      cfg_core(1, 8, 1'b0, 24'h0);
      cfg_core(2, 8, 1'b0, 24'h0);
      cfg_core(3, 3, 1'b1, 24'hFFFFFF);
      mem[3][0] = 8'd255;
      for (int a = 1; a < 256; a++) mem[3][a] = 8'(a) ^ 8'h5A;
      do_reset();
      do_start(1'b0);
      wait_done();
      final_checks();
      chk("t4b_write_count", 32'(wr_count), 32'd256);
      chk("t4b_last_addr", 32'(log_addr[255]), 32'hFF);
      chk("t4b_last_data", 32'(log_data[255]), 32'hA5);
      chk("t4b_key", 32'(key), 32'hFFFFFF);

      // 5: reset in the middle of the copy after 5 writes
      clear_mem();
      cfg_core(0, 8, 1'b0, 24'h0);
      cfg_core(1, 4, 1'b1, 24'h055555);
      cfg_core(2, 8, 1'b0, 24'h0);
      cfg_core(3, 8, 1'b0, 24'h0);
      mem[1][0] = 8'd20;
      for (int a = 1; a < 256; a++) mem[1][a] = 8'(a + 8'h30);
      do_reset();
      do_start(1'b0);
      begin
         int n = 0;
         while (wr_count < 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("t5_reached_copy", 32'(wr_count), 32'd4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      chk("t5_writes_before_rst", 32'(wr_count), 32'd5);
      chk("t5_rdy", 32'(rdy), 32'h1);
      chk("t5_pt_wren", 32'(pt_wren), 32'h0);
      chk("t5_core_rst_n", 32'(core_rst_n), 32'h0);
      chk("t5_key_valid", 32'(key_valid), 32'h0);

      // 6: one core late to come ready delays the launch
      clear_mem();
      cfg_core(0, 4, 1'b1, 24'h600000);
      cfg_core(1, 6, 1'b0, 24'h0);
      cfg_core(2, 6, 1'b0, 24'h0);
      cfg_core(3, 6, 1'b0, 24'h0);
      mem[0][0] = 8'd1; mem[0][1] = 8'h7E;
      do_reset();
      hold_rdy[2] = 1'b1;
      do_start(1'b0);
      repeat (6) @(posedge clk);
      #1;
      chk("t6_no_launch_while_waiting", 32'(en_pulses), 32'd0);
      chk("t6_core_en_idle", 32'(core_en), 32'h0);
      hold_rdy[2] = 1'b0;
      wait_done();
      final_checks();
      chk("t6_winner", 32'(winner), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
